mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between instruction
// fetch and the data stage. Data wins by default; a two-deep streak counter lets
// a waiting fetch through after two back-to-back data grants. A watchdog aborts
// any access that sees no mem_ready within MAX_WAIT cycles and latches a sticky
// error flag.
module mem_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    // fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    // data side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    // memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    // pipeline / status
    output logic              stall,
    output logic              timeout_err
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             owner_d;      // 1 = current/last access belongs to the data stage
    logic [1:0]       streak;       // consecutive data grants taken while fetch waited
    logic [CNT_W-1:0] wait_cnt;
    logic             grant_i, grant_d, complete, abort;

    // Saturating increment of the fairness streak (ceiling of 2).
    function automatic logic [1:0] streak_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd2 : s + 2'd1;
    endfunction

    // State register; async reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Arbitration, access sequencing and completion decode.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        mem_req   = 1'b0;
        if_valid  = 1'b0;
        d_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && streak == 2'd2)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    complete  = 1'b1;
                    state_nxt = DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if_valid  = !owner_d;
                d_valid   = owner_d;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access fields, fairness streak, watchdog counter and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            owner_d     <= 1'b0;
            streak      <= 2'd0;
            wait_cnt    <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_d) begin
                mem_addr  <= d_addr;
                mem_we    <= d_we;
                mem_wdata <= d_wdata;
                owner_d   <= 1'b1;
                streak    <= if_req ? streak_inc(streak) : 2'd0;
            end else if (grant_i) begin
                mem_addr  <= if_addr;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
                owner_d   <= 1'b0;
                streak    <= 2'd0;
            end

            if (mem_req && !mem_ready && !abort) wait_cnt <= wait_cnt + CNT_W'(1);
            else                                 wait_cnt <= '0;

            if (complete || abort) begin
                if (owner_d) d_rdata  <= (complete && !mem_we) ? mem_rdata : '0;
                else         if_rdata <= complete ? mem_rdata : '0;
            end

            if (abort) timeout_err <= 1'b1;
        end
    end

    // Hold the pipeline while any raised request has not yet seen its valid.
    assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule
